// File: rtl/gf_poly_mul_seq_if.sv
// Handshake bundle for gf_poly_mul_seq: operand valid/ready, result valid/ready, busy flag.
// The acc_en signal exists only when GF_POLY_MUL_ACC_EN is defined.
interface gf_poly_mul_seq_if #(
  parameter int SIZE             = 8,
  parameter int n                = 2,
  parameter int flat_size        = (n + 1) * SIZE,
  parameter int large_array_size = (2 * n + 1) * SIZE
);
  logic                        in_valid;
  logic                        in_ready;
  logic [flat_size-1:0]        flat_p;
  logic [flat_size-1:0]        flat_q;
  logic                        out_valid;
  logic                        out_ready;
  logic [large_array_size-1:0] flat_z;
  logic                        busy;
`ifdef GF_POLY_MUL_ACC_EN
  logic                        acc_en;
`endif

  modport master (
    output in_valid, flat_p, flat_q, out_ready,
`ifdef GF_POLY_MUL_ACC_EN
    output acc_en,
`endif
    input  in_ready, out_valid, flat_z, busy
  );

  modport slave (
    input  in_valid, flat_p, flat_q, out_ready,
`ifdef GF_POLY_MUL_ACC_EN
    input  acc_en,
`endif
    output in_ready, out_valid, flat_z, busy
  );
endinterface

// File: rtl/gf_poly_mul_seq.sv
// Sequential GF(2^SIZE) polynomial multiplier: one q coefficient per cycle through n+1 GF multipliers.
// Optional GF_POLY_MUL_ACC_EN adds acc_en so a product can be XOR-accumulated onto the previous result.
module gf_poly_mul_seq #(
  parameter int            SIZE             = 8,
  parameter logic [SIZE:0] PRIM_POLY        = 9'h11D,
  parameter int            n                = 2,
  parameter int            flat_size        = (n + 1) * SIZE,
  parameter int            large_array_size = (2 * n + 1) * SIZE
) (
  input logic              clk,
  input logic              rst,
  gf_poly_mul_seq_if.slave bus
);

  localparam int JW = (n < 1) ? 1 : $clog2(n + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]                  state;
  logic [JW-1:0]               j;
  logic [flat_size-1:0]        p_reg;
  logic [flat_size-1:0]        q_reg;
  logic [large_array_size-1:0] z_reg;
  logic [large_array_size-1:0] z_nxt;
  logic [SIZE-1:0]             q_j;

  // Shift-and-add multiply; the reduction folds x^SIZE back in as soon as it appears.
  function automatic logic [SIZE-1:0] gf_mul(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    logic [SIZE-1:0] r;
    logic [SIZE-1:0] aa;
    r  = '0;
    aa = a;
    for (int i = 0; i < SIZE; i++) begin
      if (b[i]) r = r ^ aa;
      aa = aa[SIZE-1] ? ((aa << 1) ^ PRIM_POLY[SIZE-1:0]) : (aa << 1);
    end
    return r;
  endfunction

  always_comb begin
    z_nxt = z_reg;
    q_j   = q_reg[int'(j) * SIZE +: SIZE];
    for (int k = 0; k <= n; k++) begin
      z_nxt[(k + int'(j)) * SIZE +: SIZE] =
        z_nxt[(k + int'(j)) * SIZE +: SIZE] ^ gf_mul(p_reg[k * SIZE +: SIZE], q_j);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      j     <= '0;
      p_reg <= '0;
      q_reg <= '0;
      z_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            p_reg <= bus.flat_p;
            q_reg <= bus.flat_q;
            j     <= '0;
            state <= MAC;
`ifdef GF_POLY_MUL_ACC_EN
            if (!bus.acc_en) z_reg <= '0;
`else
            z_reg <= '0;
`endif
          end
        end
        MAC: begin
          z_reg <= z_nxt;
          if (j == JW'(n)) begin
            state <= DONE;
          end else begin
            j <= j + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state == MAC);
  assign bus.out_valid = (state == DONE);
  assign bus.flat_z    = z_reg;

endmodule

// File: tb/tb_gf_poly_mul_seq.sv
// Directed bench for gf_poly_mul_seq (n=2 instance) plus a random n=4 instance against a division-based model.
// Acc-enable scenario is compiled in only when GF_POLY_MUL_ACC_EN is defined.
module tb_gf_poly_mul_seq;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  gf_poly_mul_seq_if #(.SIZE(8), .n(2)) bus2 ();
  gf_poly_mul_seq_if #(.SIZE(8), .n(4)) bus4 ();

  gf_poly_mul_seq #(.SIZE(8), .PRIM_POLY(9'h11D), .n(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  gf_poly_mul_seq #(.SIZE(8), .PRIM_POLY(9'h11D), .n(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference multiply: full carry-less product, then long division by 0x11D.
  function automatic logic [7:0] ref_gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) prod = prod ^ (16'(a) << i);
    for (int bit_i = 14; bit_i >= 8; bit_i--)
      if (prod[bit_i]) prod = prod ^ (16'h011D << (bit_i - 8));
    return prod[7:0];
  endfunction

  function automatic logic [71:0] ref_poly_mul4(input logic [39:0] p, input logic [39:0] q);
    logic [71:0] z;
    z = '0;
    for (int i = 0; i <= 4; i++)
      for (int k = 0; k <= 4; k++)
        z[(i + k) * 8 +: 8] = z[(i + k) * 8 +: 8] ^ ref_gf_mul(p[i * 8 +: 8], q[k * 8 +: 8]);
    return z;
  endfunction

  // Accept one operation on the n=2 instance and wait (bounded) for out_valid.
  task automatic run2(input logic [23:0] p, input logic [23:0] q,
                      output logic [1:0] post_accept, output logic [39:0] z, output int lat);
    bus2.flat_p   = p;
    bus2.flat_q   = q;
    bus2.in_valid = 1'b1;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    bus2.flat_p   = '1;
    bus2.flat_q   = '1;
    post_accept   = {bus2.in_ready, bus2.busy};
    lat = 0;
    while (!bus2.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    z = bus2.flat_z;
  endtask

  task automatic release2();
    bus2.out_ready = 1'b1;
    @(posedge clk); #1;
    bus2.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({bus2.in_ready, bus2.out_valid, bus2.busy} !== 3'b100) begin
      bad++;
      $display("[TB] FAIL reset_flags2 got=%b want=100", {bus2.in_ready, bus2.out_valid, bus2.busy});
    end
    total++;
    if (bus2.flat_z !== 40'h0) begin
      bad++;
      $display("[TB] FAIL reset_z2 got=%h want=0", bus2.flat_z);
    end
    total++;
    if ({bus4.in_ready, bus4.out_valid, bus4.busy, bus4.flat_z} !== {3'b100, 72'h0}) begin
      bad++;
      $display("[TB] FAIL reset_n4 got=%b/%h want=100/0", {bus4.in_ready, bus4.out_valid, bus4.busy}, bus4.flat_z);
    end
  endtask

  task automatic test_basic();
    logic [1:0]  pa;
    logic [39:0] z;
    int          lat;
    run2(24'h040105, 24'h020003, pa, z, lat);
    total++;
    if (pa !== 2'b01) begin
      bad++;
      $display("[TB] FAIL basic_accept ready_busy got=%b want=01", pa);
    end
    total++;
    if (lat !== 3) begin
      bad++;
      $display("[TB] FAIL basic_latency got=%0d want=3", lat);
    end
    total++;
    if (z !== 40'h080206030F) begin
      bad++;
      $display("[TB] FAIL basic_z got=%h want=080206030f", z);
    end
    release2();
    total++;
    if ({bus2.in_ready, bus2.out_valid, bus2.flat_z} !== {2'b10, 40'h080206030F}) begin
      bad++;
      $display("[TB] FAIL basic_release got=%b/%h want=10/080206030f", {bus2.in_ready, bus2.out_valid}, bus2.flat_z);
    end
  endtask

  task automatic test_reduction();
    logic [1:0]  pa;
    logic [39:0] z;
    int          lat;
    run2(24'h000080, 24'h000002, pa, z, lat);
    total++;
    if (z !== 40'h000000001D) begin
      bad++;
      $display("[TB] FAIL reduction_z got=%h want=000000001d", z);
    end
    release2();
  endtask

  task automatic test_backpressure();
    logic [1:0]  pa;
    logic [39:0] z;
    int          lat;
    run2(24'h040105, 24'h020003, pa, z, lat);
    bus2.flat_p   = 24'h0000FF;
    bus2.flat_q   = 24'h0000FF;
    bus2.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++;
      if ({bus2.out_valid, bus2.in_ready, bus2.flat_z} !== {2'b10, 40'h080206030F}) begin
        bad++;
        $display("[TB] FAIL backpressure_hold cycle=%0d got=%b/%h want=10/080206030f",
                 c, {bus2.out_valid, bus2.in_ready}, bus2.flat_z);
      end
    end
    bus2.in_valid = 1'b0;
    release2();
    total++;
    if ({bus2.out_valid, bus2.in_ready, bus2.busy, bus2.flat_z} !== {3'b010, 40'h080206030F}) begin
      bad++;
      $display("[TB] FAIL backpressure_release got=%b/%h want=010/080206030f",
               {bus2.out_valid, bus2.in_ready, bus2.busy}, bus2.flat_z);
    end
  endtask

  task automatic test_reset_mid_mac();
    logic [1:0]  pa;
    logic [39:0] z;
    int          lat;
    bus2.flat_p   = 24'h040105;
    bus2.flat_q   = 24'h020003;
    bus2.in_valid = 1'b1;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({bus2.in_ready, bus2.out_valid, bus2.busy, bus2.flat_z} !== {3'b100, 40'h0}) begin
      bad++;
      $display("[TB] FAIL midmac_reset got=%b/%h want=100/0",
               {bus2.in_ready, bus2.out_valid, bus2.busy}, bus2.flat_z);
    end
    run2(24'h000080, 24'h000002, pa, z, lat);
    total++;
    if (z !== 40'h000000001D || lat !== 3) begin
      bad++;
      $display("[TB] FAIL midmac_rerun got=%h lat=%0d want=000000001d lat=3", z, lat);
    end
    release2();
  endtask

`ifdef GF_POLY_MUL_ACC_EN
  task automatic test_acc_en();
    logic [1:0]  pa;
    logic [39:0] z;
    int          lat;
    bus2.acc_en = 1'b0;
    run2(24'h040105, 24'h020003, pa, z, lat);
    release2();
    total++;
    if (z !== 40'h080206030F) begin
      bad++;
      $display("[TB] FAIL acc_first got=%h want=080206030f", z);
    end
    bus2.acc_en = 1'b1;
    run2(24'h040105, 24'h020003, pa, z, lat);
    release2();
    total++;
    if (z !== 40'h0) begin
      bad++;
      $display("[TB] FAIL acc_sum got=%h want=0", z);
    end
    bus2.acc_en = 1'b0;
    run2(24'h040105, 24'h020003, pa, z, lat);
    release2();
    total++;
    if (z !== 40'h080206030F) begin
      bad++;
      $display("[TB] FAIL acc_cleared got=%h want=080206030f", z);
    end
  endtask
`endif

  task automatic test_random_n4();
    logic [63:0] r1;
    logic [63:0] r2;
    logic [39:0] p;
    logic [39:0] q;
    logic [71:0] want;
    int          lat;
    for (int it = 0; it < 200; it++) begin
      r1 = {$urandom(), $urandom()};
      r2 = {$urandom(), $urandom()};
      p  = r1[39:0];
      q  = r2[39:0];
      want = ref_poly_mul4(p, q);
      bus4.flat_p   = p;
      bus4.flat_q   = q;
      bus4.in_valid = 1'b1;
      @(posedge clk); #1;
      bus4.in_valid = 1'b0;
      lat = 0;
      while (!bus4.out_valid && lat < 30) begin
        @(posedge clk); #1;
        lat++;
      end
      total++;
      if (lat !== 5) begin
        bad++;
        $display("[TB] FAIL n4_latency it=%0d got=%0d want=5", it, lat);
      end
      total++;
      if (bus4.flat_z !== want) begin
        bad++;
        $display("[TB] FAIL n4_product it=%0d got=%h want=%h", it, bus4.flat_z, want);
      end
      bus4.out_ready = 1'b1;
      @(posedge clk); #1;
      bus4.out_ready = 1'b0;
    end
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    rst            = 1'b1;
    bus2.in_valid  = 1'b0;
    bus2.flat_p    = '0;
    bus2.flat_q    = '0;
    bus2.out_ready = 1'b0;
    bus4.in_valid  = 1'b0;
    bus4.flat_p    = '0;
    bus4.flat_q    = '0;
    bus4.out_ready = 1'b0;
`ifdef GF_POLY_MUL_ACC_EN
    bus2.acc_en    = 1'b0;
    bus4.acc_en    = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_basic();
    test_reduction();
    test_backpressure();
    test_reset_mid_mac();
`ifdef GF_POLY_MUL_ACC_EN
    test_acc_en();
`endif
    test_random_n4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
